vreg_group_reader: RTL and testbench

- Parametrised, sequenced successor to the combinational vector operand selector.
- Reads an aligned LMUL register group (1/2/4/8 registers) from the flattened vector register file.
- Streams the group as PORT_REGS-register beats on a valid/ready port, so the operand bus is narrower than the widest group.
- Sits between the register-file storage and the vector ALU operand input.

---
 rtl/vreg_group_reader.sv | 148 ++++++++++++++
 tb/tb_vreg_group_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_group_reader.sv
// Streams an aligned LMUL register group from the flattened vector register file as PORT_REGS-wide beats.
// Optional macro VREG_RD_FRAC_EN enables fractional LMUL codes 101/110/111 (masked single-register beat).
module vreg_group_reader #(
  parameter int NUM_REGS  = 32,
  parameter int REG_W     = 32,
  parameter int PORT_REGS = 2,
  parameter int SEL_W     = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REGS*REG_W-1:0]     registers,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [SEL_W-1:0]              req_reg,
  input  logic [2:0]                    req_vlmul,
  output logic                          beat_valid,
  input  logic                          beat_ready,
  output logic [PORT_REGS*REG_W-1:0]    beat_data,
  output logic [2:0]                    beat_idx,
  output logic                          beat_last,
  output logic                          req_err
);
  localparam int BEAT_W = PORT_REGS * REG_W;

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;

  logic [SEL_W-1:0]  base_q;
  logic [3:0]        grp_q;
  logic [2:0]        last_q;

  logic [3:0]        req_grp;
  logic [2:0]        req_last;
  logic              req_legal;
  logic [REG_W-1:0]  frac_mask;

  logic              load, err_nxt;
  logic [SEL_W-1:0]  ld_base;
  logic [3:0]        ld_grp;
  logic [2:0]        ld_idx, ld_last;
  logic [BEAT_W-1:0] ld_data;
  logic [5:0]        lane_off;
  logic [SEL_W-1:0]  lane_sel;

  assign req_ready = (state == IDLE);

  // Request decode: group size, beat count, legality and fractional lane-0 mask
  always_comb begin
    req_grp   = 4'd1;
    req_legal = 1'b0;
    frac_mask = '1;
    if (!req_vlmul[2]) begin
      req_grp   = 4'd1 << req_vlmul[1:0];
      req_legal = ((req_reg & SEL_W'(req_grp - 4'd1)) == '0);
    end
`ifdef VREG_RD_FRAC_EN
    else if (req_vlmul[1:0] != 2'b00) begin
      req_legal = 1'b1;
      case (req_vlmul[1:0])
        2'b01:   frac_mask = frac_mask >> (REG_W - REG_W / 8);
        2'b10:   frac_mask = frac_mask >> (REG_W - REG_W / 4);
        default: frac_mask = frac_mask >> (REG_W - REG_W / 2);
      endcase
    end
`endif
    req_last = (req_grp > 4'(PORT_REGS)) ? 3'((req_grp / 4'(PORT_REGS)) - 4'd1) : 3'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    err_nxt   = 1'b0;
    ld_base   = base_q;
    ld_grp    = grp_q;
    ld_idx    = beat_idx + 3'd1;
    ld_last   = last_q;
    case (state)
      IDLE: begin
        ld_base = req_reg;
        ld_grp  = req_grp;
        ld_idx  = 3'd0;
        ld_last = req_last;
        if (req_valid) begin
          if (req_legal) begin
            load      = 1'b1;
            state_nxt = SEND;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (beat_valid && beat_ready) begin
          if (beat_last) state_nxt = IDLE;
          else           load      = 1'b1;
        end
      end
    endcase
  end

  // Beat assembly: lane k reads r[base + idx*PORT_REGS + k]; lanes past the group are zero
  always_comb begin
    ld_data  = '0;
    lane_off = '0;
    lane_sel = '0;
    for (int k = 0; k < PORT_REGS; k++) begin
      lane_off = 6'(ld_idx) * 6'(PORT_REGS) + 6'(k);
      lane_sel = ld_base + SEL_W'(lane_off);
      if (lane_off < 6'(ld_grp))
        ld_data[k*REG_W +: REG_W] = registers[lane_sel*REG_W +: REG_W];
    end
    if (state == IDLE)
      ld_data[REG_W-1:0] = ld_data[REG_W-1:0] & frac_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_valid <= 1'b0;
      beat_data  <= '0;
      beat_idx   <= 3'd0;
      beat_last  <= 1'b0;
      req_err    <= 1'b0;
      base_q     <= '0;
      grp_q      <= 4'd1;
      last_q     <= 3'd0;
    end else begin
      req_err <= err_nxt;
      if (load) begin
        beat_valid <= 1'b1;
        beat_data  <= ld_data;
        beat_idx   <= ld_idx;
        beat_last  <= (ld_idx == ld_last);
      end else if (state == SEND && beat_valid && beat_ready && beat_last) begin
        beat_valid <= 1'b0;
      end
      if (load && state == IDLE) begin
        base_q <= req_reg;
        grp_q  <= req_grp;
        last_q <= req_last;
      end
    end
  end
endmodule

// File: tb/tb_vreg_group_reader.sv
// Scoreboard bench for vreg_group_reader: stimulus pushes model beats, a negedge monitor pops and compares.
module tb_vreg_group_reader;
  localparam int NUM_REGS  = 32;
  localparam int REG_W     = 32;
  localparam int PORT_REGS = 2;
  localparam int SEL_W     = 5;
  localparam int BEAT_W    = PORT_REGS * REG_W;
  localparam int CW        = BEAT_W + 5;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REGS*REG_W-1:0] registers;
  logic                      req_valid = 1'b0;
  logic                      req_ready;
  logic [SEL_W-1:0]          req_reg = '0;
  logic [2:0]                req_vlmul = '0;
  logic                      beat_valid;
  logic                      beat_ready;
  logic [BEAT_W-1:0]         beat_data;
  logic [2:0]                beat_idx;
  logic                      beat_last;
  logic                      req_err;

  logic [REG_W-1:0] rf [NUM_REGS];
  logic rdy_rand = 1'b0, rdy_force = 1'b1, rnd_bit = 1'b1;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [2:0]        idx;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  int    err_exp = 0;
  int    tests = 0;
  int    fails = 0;

  vreg_group_reader #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .PORT_REGS(PORT_REGS), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .registers(registers),
    .req_valid(req_valid), .req_ready(req_ready), .req_reg(req_reg), .req_vlmul(req_vlmul),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
    .beat_idx(beat_idx), .beat_last(beat_last), .req_err(req_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    registers = '0;
    for (int i = 0; i < NUM_REGS; i++) registers[i*REG_W +: REG_W] = rf[i];
  end

  assign beat_ready = rdy_rand ? rnd_bit : rdy_force;

  initial forever begin
    @(posedge clk);
    #1 rnd_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: legality and expected beats from the group/beat arithmetic
  function automatic bit is_legal(input logic [2:0] vl, input logic [SEL_W-1:0] r);
    if (vl <= 3'd3) return (int'(r) % (1 << vl)) == 0;
`ifdef VREG_RD_FRAC_EN
    if (vl >= 3'd5) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic push_expect(input logic [SEL_W-1:0] r, input logic [2:0] vl);
    beat_t e;
    logic [REG_W-1:0] m;
    int g, n, off;
    if (!is_legal(vl, r)) begin
      err_exp++;
      return;
    end
    if (vl >= 3'd5) begin
      m = '1;
      m = m >> (REG_W - (REG_W >> (8 - int'(vl))));
      e.data = '0;
      e.data[REG_W-1:0] = rf[r] & m;
      e.idx  = 3'd0;
      e.last = 1'b1;
      exp_q.push_back(e);
      return;
    end
    g = 1 << vl;
    n = (g > PORT_REGS) ? g / PORT_REGS : 1;
    for (int b = 0; b < n; b++) begin
      e.data = '0;
      for (int k = 0; k < PORT_REGS; k++) begin
        off = b * PORT_REGS + k;
        if (off < g) e.data[k*REG_W +: REG_W] = rf[(int'(r) + off) % NUM_REGS];
      end
      e.idx  = 3'(b);
      e.last = (b == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!req_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check("idle_wait", CW'(req_ready), CW'(1));
  endtask

  task automatic issue(input logic [SEL_W-1:0] r, input logic [2:0] vl);
    wait_idle();
    push_expect(r, vl);
    req_valid = 1'b1;
    req_reg   = r;
    req_vlmul = vl;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Monitor: pops one expected beat per handshake, checks stall stability and req_err pulses
  initial begin
    beat_t e, held;
    bit stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
        continue;
      end
      if (stall) check("stall_hold", {beat_valid, beat_data, beat_idx, beat_last}, {1'b1, held});
      stall = beat_valid && !beat_ready;
      held  = {beat_data, beat_idx, beat_last};
      if (beat_valid && beat_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got idx %0d data %h expected no beat", beat_idx, beat_data);
        end else begin
          e = exp_q.pop_front();
          check("beat", {1'b1, beat_data, beat_idx, beat_last}, {1'b1, e});
        end
      end
      if (req_err) begin
        tests++;
        if (err_exp > 0) err_exp--;
        else begin
          fails++;
          $display("FAIL req_err_pulse: got 1 expected 0");
        end
      end
    end
  end

  initial begin
    int cnt;
    logic [SEL_W-1:0] r;
    logic [2:0] vl;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'h1000_0000 + 32'(i);

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", CW'(req_ready), CW'(1));
    check("rst_beat_valid", CW'(beat_valid), CW'(0));
    check("rst_beat_data", CW'(beat_data), CW'(0));
    check("rst_idx_last_err", CW'({beat_idx, beat_last, req_err}), CW'(0));
    rst = 1'b0;

    // 8-register group, four beats, ready held high
    issue(5'd8, 3'd3);
    check("t1_first_valid", CW'(beat_valid), CW'(1));
    check("t1_first_data", CW'(beat_data), CW'({32'h1000_0009, 32'h1000_0008}));
    cnt = 0;
    while (!req_ready && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("t1_ready_latency", CW'(cnt), CW'(4));

    issue(5'd5, 3'd0);
    check("t2_data", CW'(beat_data), CW'({32'h0, 32'h1000_0005}));
    check("t2_last", CW'(beat_last), CW'(1));
    wait_idle();

    issue(5'd6, 3'd2);
    check("t3_err", CW'({req_err, beat_valid, req_ready}), CW'(3'b101));
    @(posedge clk); #1;
    check("t3_err_clear", CW'(req_err), CW'(0));
    issue(5'd6, 3'd4);
    check("t3_err_res", CW'({req_err, beat_valid, req_ready}), CW'(3'b101));
    @(posedge clk); #1;

    // Stall on first beat while r28 is overwritten
    rdy_force = 1'b0;
    issue(5'd28, 3'd2);
    rf[28] = 32'hAAAA_5555;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("t4_stall_data", CW'({beat_valid, beat_data}), CW'({1'b1, 32'h1000_001D, 32'h1000_001C}));
    rdy_force = 1'b1;
    wait_idle();

    // Reset in the middle of a group
    issue(5'd16, 3'd3);
    @(posedge clk); #1;
    check("t5_idx1", CW'(beat_idx), CW'(1));
    rst = 1'b1;
    #1;
    check("t5_rst_outputs", CW'({beat_valid, req_ready, beat_idx, beat_last}), CW'(6'b010000));
    check("t5_rst_data", CW'(beat_data), CW'(0));
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    issue(5'd0, 3'd3);
    check("t5_restart_idx", CW'({beat_valid, beat_idx}), CW'(4'b1000));
    wait_idle();

    rf[3] = 32'hDEAD_BEEF;
    issue(5'd3, 3'd6);
`ifdef VREG_RD_FRAC_EN
    check("t6_frac", CW'({beat_valid, beat_last, beat_data}), CW'({2'b11, 64'h0000_00EF}));
`else
    check("t6_frac_err", CW'({req_err, beat_valid}), CW'(2'b10));
`endif
    wait_idle();

    // Randomized requests with random backpressure
    rdy_rand = 1'b1;
    repeat (60) begin
      wait_idle();
      rf[$urandom_range(0, NUM_REGS - 1)] = $urandom;
      vl = 3'($urandom_range(0, 7));
      r  = SEL_W'($urandom);
      if (vl <= 3'd3 && $urandom_range(0, 3) != 0) r = r & ~SEL_W'((1 << vl) - 1);
      issue(r, vl);
    end
    wait_idle();
    cnt = 0;
    while ((exp_q.size() != 0 || err_exp != 0) && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_beats", CW'(exp_q.size()), CW'(0));
    check("drain_errs", CW'(err_exp), CW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
